sram_axi_bridge: RTL and testbench
==================================

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters: none; AXI ID width fixed at 4, data and address widths fixed at 32.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 inst_sram_req/wr/size[1:0]/addr[31:0]/wstrb[3:0]/wdata[31:0]  in  instruction port, SRAM-like request.
REQ-005 inst_sram_addr_ok, inst_sram_data_ok  out  1 each; inst_sram_rdata  out  32.
REQ-006 data_sram_req/wr/size[1:0]/addr[31:0]/wstrb[3:0]/wdata[31:0]  in  data port, SRAM-like request.
REQ-007 data_sram_addr_ok, data_sram_data_ok  out  1 each; data_sram_rdata  out  32.
REQ-008 AXI AR: arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid  out; arready  in.
REQ-009 AXI R: rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out.
REQ-010 AXI AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out (same widths as AR); awready  in.
REQ-011 AXI W: wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid  out; wready  in.
REQ-012 AXI B: bid[3:0], bresp[1:0], bvalid  in; bready  out.

Function
REQ-013 Constants: arlen=awlen=0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, wlast=1, awid=wid=1.
REQ-014 arsize/awsize = {1'b0, size}, with size taken from the accepted request.
REQ-015 Read FSM states: R_IDLE -> R_AR (arvalid=1) -> R_DATA (rready=1) -> R_IDLE; at most one read outstanding.
REQ-016 Write FSM states: W_IDLE -> W_REQ (awvalid and wvalid held independently until each handshake) -> W_RESP (bready=1) -> W_IDLE.
REQ-017 W_REQ exits only after both AW and W handshakes; the two may complete in the same cycle or in either order.
REQ-018 Data read accept: data_sram_addr_ok=1 when data_sram_req & !wr & R_IDLE & W_IDLE; arid=1.
REQ-019 Data write accept: data_sram_addr_ok=1 when data_sram_req & wr & W_IDLE & no data read outstanding.
REQ-020 Inst read accept: inst_sram_addr_ok=1 when inst_sram_req & R_IDLE & no data read accepted this cycle; arid=0.
REQ-021 Priority: a pending data request blocks inst accept in the same cycle, even if the data request is itself blocked.
REQ-022 inst_sram_wr=1 is never issued as a write; it is treated as a read.
REQ-023 addr, size, wstrb and wdata are latched on the accept cycle; AXI outputs are driven only from latched registers.
REQ-024 arvalid/awvalid/wvalid rise the cycle after accept and stay high until the handshake; payload is held stable.
REQ-025 On R handshake (rvalid & rready), rdata is registered; the cycle after, exactly one of inst/data data_ok pulses for one cycle, selected by rid[0].
REQ-026 On B handshake, data_sram_data_ok pulses one cycle later; rdata is don't-care.
REQ-027 *_rdata holds its value until the next read completion.
REQ-028 rresp and bresp are ignored; no error path.
REQ-029 Minimum read latency with zero-wait slave: accept at t, AR handshake at t+1, R handshake at t+2, data_ok at t+3.

Reset
REQ-030 Asynchronous assertion: FSMs go to R_IDLE/W_IDLE; arvalid, awvalid, wvalid, rready, bready, all addr_ok, and all data_ok go to 0; rdata registers go to 0.
REQ-031 Reset mid-transaction abandons the transaction; no data_ok is produced for it after release.
REQ-032 No request is accepted in the cycle resetn deasserts.

Verification
REQ-033 Inst read, addr 0x1c000000, zero-wait slave -> arid=0, araddr=0x1c000000, arsize=2; rdata=0x12345678 -> inst_sram_data_ok pulses at t+3 with 0x12345678.
REQ-034 Simultaneous inst and data read requests -> data accepted first (arid=1); inst accepted on the cycle after R_IDLE returns; rid routes each result to the correct port.
REQ-035 Data write, addr 0x8, wstrb 0xF, wdata 0xDEADBEEF; awready low 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held; data_ok pulses the cycle after bvalid.
REQ-036 Data read requested while a write is in W_RESP -> no addr_ok until W_IDLE; AR issued afterwards.
REQ-037 resetn pulled low while arvalid=1 -> arvalid=0 immediately; after release no spurious data_ok, and a new request proceeds normally.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// Signals between the CPU-side SRAM-like ports and the AXI3 master of sram_axi_bridge.
// The bridge connects through the master modport; the CPU and AXI-slave environment uses slave.
interface sram_axi_bridge_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges SRAM-like instruction and data ports onto a single-beat AXI3 master.
// One read and one write may be in flight; data requests take priority over instruction fetches.
module sram_axi_bridge (
    input  logic              clk,
    input  logic              resetn,
    sram_axi_bridge_if.master bus
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

    rd_state_e   rd_state_q;
    wr_state_e   wr_state_q;
    logic        run_q;

    logic        arvalid_q, rready_q, ar_data_q;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic [31:0] inst_rdata_q, data_rdata_q;
    logic        inst_dok_q, rd_dok_q;

    logic        awvalid_q, wvalid_q, bready_q, wr_dok_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [1:0]  awsize_q;
    logic [3:0]  wstrb_q;
    logic        aw_pend_d, w_pend_d;

    logic        data_rd_busy, data_rd_acc, data_wr_acc, inst_acc;

    // A data request of either kind blocks the fetch port, even when it cannot be taken itself.
    assign data_rd_busy = (rd_state_q != R_IDLE) && ar_data_q;
    assign data_rd_acc  = run_q && bus.data_sram_req && !bus.data_sram_wr
                          && (rd_state_q == R_IDLE) && (wr_state_q == W_IDLE);
    assign data_wr_acc  = run_q && bus.data_sram_req && bus.data_sram_wr
                          && (wr_state_q == W_IDLE) && !data_rd_busy;
    assign inst_acc     = run_q && bus.inst_sram_req && (rd_state_q == R_IDLE)
                          && !bus.data_sram_req;

    assign aw_pend_d = awvalid_q && !bus.awready;
    assign w_pend_d  = wvalid_q && !bus.wready;

    // Holds off acceptance for the cycle in which reset releases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) run_q <= 1'b0;
        else         run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q   <= R_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ar_data_q    <= 1'b0;
            araddr_q     <= '0;
            arsize_q     <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_dok_q   <= 1'b0;
            rd_dok_q     <= 1'b0;
        end else begin
            inst_dok_q <= 1'b0;
            rd_dok_q   <= 1'b0;
            case (rd_state_q)
                R_IDLE: begin
                    if (data_rd_acc || inst_acc) begin
                        araddr_q   <= data_rd_acc ? bus.data_sram_addr : bus.inst_sram_addr;
                        arsize_q   <= data_rd_acc ? bus.data_sram_size : bus.inst_sram_size;
                        ar_data_q  <= data_rd_acc;
                        arvalid_q  <= 1'b1;
                        rd_state_q <= R_AR;
                    end
                end
                R_AR: begin
                    if (bus.arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rvalid) begin
                        rready_q   <= 1'b0;
                        rd_state_q <= R_IDLE;
                        if (bus.rid[0]) begin
                            data_rdata_q <= bus.rdata;
                            rd_dok_q     <= 1'b1;
                        end else begin
                            inst_rdata_q <= bus.rdata;
                            inst_dok_q   <= 1'b1;
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= W_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wr_dok_q   <= 1'b0;
            awaddr_q   <= '0;
            awsize_q   <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end else begin
            wr_dok_q <= 1'b0;
            case (wr_state_q)
                W_IDLE: begin
                    if (data_wr_acc) begin
                        awaddr_q   <= bus.data_sram_addr;
                        awsize_q   <= bus.data_sram_size;
                        wstrb_q    <= bus.data_sram_wstrb;
                        wdata_q    <= bus.data_sram_wdata;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        wr_state_q <= W_REQ;
                    end
                end
                W_REQ: begin
                    awvalid_q <= aw_pend_d;
                    wvalid_q  <= w_pend_d;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q   <= 1'b1;
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.bvalid) begin
                        bready_q   <= 1'b0;
                        wr_dok_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign bus.inst_sram_addr_ok = inst_acc;
    assign bus.inst_sram_data_ok = inst_dok_q;
    assign bus.inst_sram_rdata   = inst_rdata_q;
    assign bus.data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign bus.data_sram_data_ok = rd_dok_q || wr_dok_q;
    assign bus.data_sram_rdata   = data_rdata_q;

    assign bus.arid    = {3'b000, ar_data_q};
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, arsize_q};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign bus.awid    = 4'd1;
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = {1'b0, awsize_q};
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = awvalid_q;
    assign bus.wid     = 4'd1;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;

    // Fetch-port write fields, response codes and upper ID bits carry no meaning here.
    logic unused_in;
    assign unused_in = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                         bus.rid[3:1], bus.rresp, bus.rlast, bus.bid, bus.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: request drivers push expectations, an AXI slave
// model and a port monitor pop and compare them against a simple memory reference.
module tb_sram_axi_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_axi_bridge_if bus();
    sram_axi_bridge dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct { logic is_wr; logic [31:0] data; } dexp_t;
    typedef struct { logic [31:0] addr; logic [1:0] size; logic [3:0] id; } arexp_t;
    typedef struct { logic [31:0] addr; logic [1:0] size; logic [3:0] strb; logic [31:0] data; } awexp_t;

    logic [31:0] exp_inst[$];
    dexp_t       exp_data[$];
    arexp_t      exp_ar[$];
    awexp_t      exp_aw[$];
    logic [31:0] slv_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int mode = 0, ar_block = 0, aw_block = 0, b_block = 0;
    int b_cyc = 0, inst_dok_cyc = 0, data_dok_cyc = 0, wr_dok_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic go();
        return (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        slv_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // AXI slave: decisions at the falling edge, fire predicted for the next rising edge.
    initial begin : axi_slave
        logic r_fire, b_fire, aw_got, w_got;
        logic [31:0] aw_addr_c, w_data_c;
        logic [1:0] aw_size_c;
        logic [3:0] w_strb_c;
        arexp_t rd_q[$];
        logic [31:0] d;
        r_fire = 0; b_fire = 0; aw_got = 0; w_got = 0;
        aw_addr_c = 0; w_data_c = 0; aw_size_c = 0; w_strb_c = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = 0; bus.bresp = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                r_fire = 0; b_fire = 0; aw_got = 0; w_got = 0;
                rd_q.delete();
                continue;
            end
            if (r_fire) begin bus.rvalid = 0; r_fire = 0; end
            if (!bus.rvalid && rd_q.size() > 0 && go()) begin
                bus.rvalid = 1;
                bus.rid    = rd_q[0].id;
                bus.rdata  = slv_mem.exists(rd_q[0].addr) ? slv_mem[rd_q[0].addr] : init_word(rd_q[0].addr);
                bus.rresp  = 2'($urandom);
                bus.rlast  = 1;
                void'(rd_q.pop_front());
            end
            if (bus.rvalid && bus.rready) r_fire = 1;

            if (ar_block > 0 && bus.arvalid) begin bus.arready = 0; ar_block--; end
            else bus.arready = go();
            if (bus.arvalid && bus.arready) begin
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else begin
                    check("araddr", bus.araddr, exp_ar[0].addr);
                    check("arsize", {29'b0, bus.arsize}, {30'b0, exp_ar[0].size});
                    check("arid", {28'b0, bus.arid}, {28'b0, exp_ar[0].id});
                    void'(exp_ar.pop_front());
                end
                check("ar_const", {13'b0, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
                      {13'b0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
                rd_q.push_back('{addr: bus.araddr, size: bus.arsize[1:0], id: bus.arid});
            end

            if (b_fire) begin bus.bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; end
            if (!bus.bvalid && aw_got && w_got) begin
                if (b_block > 0) b_block--;
                else if (go()) begin
                    if (exp_aw.size() == 0) fail("aw_unexpected");
                    else begin
                        check("awaddr", aw_addr_c, exp_aw[0].addr);
                        check("awsize", {30'b0, aw_size_c}, {30'b0, exp_aw[0].size});
                        check("wstrb", {28'b0, w_strb_c}, {28'b0, exp_aw[0].strb});
                        check("wdata", w_data_c, exp_aw[0].data);
                        void'(exp_aw.pop_front());
                    end
                    d = slv_mem.exists(aw_addr_c) ? slv_mem[aw_addr_c] : init_word(aw_addr_c);
                    slv_mem[aw_addr_c] = merge(d, w_data_c, w_strb_c);
                    bus.bvalid = 1;
                    bus.bid    = 4'd1;
                    bus.bresp  = 2'($urandom);
                end
            end
            if (bus.bvalid && bus.bready) begin b_fire = 1; b_cyc = cyc; end

            if (aw_block > 0 && bus.awvalid) begin bus.awready = 0; aw_block--; end
            else bus.awready = go();
            bus.wready = go();
            if (bus.awvalid && bus.awready) begin
                if (aw_got) fail("aw_duplicate");
                aw_got = 1; aw_addr_c = bus.awaddr; aw_size_c = bus.awsize[1:0];
                check("aw_const", {9'b0, bus.awid, bus.awlen, bus.awburst, bus.awlock, bus.awcache, bus.awprot,
                      bus.awsize[2]}, {9'b0, 4'd1, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0, 1'b0});
            end
            if (bus.wvalid && bus.wready) begin
                if (w_got) fail("w_duplicate");
                w_got = 1; w_data_c = bus.wdata; w_strb_c = bus.wstrb;
                check("w_const", {27'b0, bus.wid, bus.wlast}, {27'b0, 4'd1, 1'b1});
            end
        end
    end

    initial begin : monitor
        dexp_t e;
        forever begin
            @(negedge clk);
            if (bus.inst_sram_data_ok) begin
                inst_dok_cyc = cyc;
                if (exp_inst.size() == 0) fail("inst_spurious_data_ok");
                else check("inst_rdata", bus.inst_sram_rdata, exp_inst.pop_front());
            end
            if (bus.data_sram_data_ok) begin
                data_dok_cyc = cyc;
                if (exp_data.size() == 0) fail("data_spurious_data_ok");
                else begin
                    e = exp_data.pop_front();
                    if (e.is_wr) wr_dok_cyc = cyc;
                    else check("data_rdata", bus.data_sram_rdata, e.data);
                end
            end
        end
    end

    // Both drivers must be called on a falling edge; they return on a falling edge.
    task automatic inst_issue(input logic [31:0] a, input logic [1:0] sz, input logic w, output int acc);
        int budget;
        budget = 0;
        acc = -1;
        bus.inst_sram_req = 1; bus.inst_sram_addr = a; bus.inst_sram_size = sz; bus.inst_sram_wr = w;
        bus.inst_sram_wstrb = 4'($urandom); bus.inst_sram_wdata = $urandom;
        while (budget < 3000) begin
            #1;
            if (bus.inst_sram_addr_ok) begin
                acc = cyc;
                exp_inst.push_back(ref_read(a));
                exp_ar.push_back('{addr: a, size: sz, id: 4'd0});
                break;
            end
            @(negedge clk);
            budget++;
        end
        if (acc < 0) fail("inst_accept_timeout");
        @(negedge clk);
        bus.inst_sram_req = 0;
    endtask

    task automatic data_issue(input logic [31:0] a, input logic [1:0] sz, input logic w,
                              input logic [3:0] s, input logic [31:0] d, output int acc);
        int budget;
        budget = 0;
        acc = -1;
        bus.data_sram_req = 1; bus.data_sram_addr = a; bus.data_sram_size = sz; bus.data_sram_wr = w;
        bus.data_sram_wstrb = s; bus.data_sram_wdata = d;
        while (budget < 3000) begin
            #1;
            if (bus.data_sram_addr_ok) begin
                acc = cyc;
                if (w) begin
                    exp_aw.push_back('{addr: a, size: sz, strb: s, data: d});
                    ref_mem[a] = merge(ref_read(a), d, s);
                    exp_data.push_back('{is_wr: 1'b1, data: 32'h0});
                end else begin
                    exp_ar.push_back('{addr: a, size: sz, id: 4'd1});
                    exp_data.push_back('{is_wr: 1'b0, data: ref_read(a)});
                end
                break;
            end
            @(negedge clk);
            budget++;
        end
        if (acc < 0) fail("data_accept_timeout");
        @(negedge clk);
        bus.data_sram_req = 0;
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 0;
        while (exp_inst.size() + exp_data.size() + exp_ar.size() + exp_aw.size() > 0 && budget < 3000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (budget >= 3000) fail(name);
        @(negedge clk);
    endtask

    initial begin : main
        int acc_a, acc_b;
        bus.inst_sram_req = 1; bus.inst_sram_wr = 0; bus.inst_sram_size = 2'd2;
        bus.inst_sram_addr = 32'h1c00_0000; bus.inst_sram_wstrb = 0; bus.inst_sram_wdata = 0;
        bus.data_sram_req = 1; bus.data_sram_wr = 0; bus.data_sram_size = 2'd2;
        bus.data_sram_addr = 32'h0000_1000; bus.data_sram_wstrb = 0; bus.data_sram_wdata = 0;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {24'b0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
              bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.inst_sram_data_ok | bus.data_sram_data_ok}, 32'h0);
        check("reset_inst_rdata", bus.inst_sram_rdata, 32'h0);
        check("reset_data_rdata", bus.data_sram_rdata, 32'h0);
        #2 resetn = 1;
        #1 check("release_no_accept", {30'b0, bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 32'h0);
        @(negedge clk);
        bus.inst_sram_req = 0; bus.data_sram_req = 0;
        repeat (2) @(negedge clk);

        // Fetch with a zero-wait slave: data_ok three cycles after accept.
        preload(32'h1c00_0000, 32'h1234_5678);
        inst_issue(32'h1c00_0000, 2'd2, 1'b0, acc_a);
        wait_drain("drain_inst_latency");
        check("inst_latency", 32'(inst_dok_cyc - acc_a), 32'd3);

        // Simultaneous fetch and data read: data goes first.
        fork
            inst_issue(32'h1c00_0040, 2'd2, 1'b1, acc_a);
            data_issue(32'h0000_1004, 2'd1, 1'b0, 4'h0, 32'h0, acc_b);
        join
        wait_drain("drain_dual_read");
        check("data_before_inst", 32'(acc_a > acc_b), 32'd1);

        // Write with AW stalled three cycles and W taken immediately.
        aw_block = 3;
        data_issue(32'h0000_0008, 2'd2, 1'b1, 4'hF, 32'hDEAD_BEEF, acc_a);
        check("wr_c1_valids", {30'b0, bus.awvalid, bus.wvalid}, 32'h3);
        @(negedge clk);
        check("wr_c2_valids", {30'b0, bus.awvalid, bus.wvalid}, 32'h2);
        @(negedge clk);
        check("wr_c3_valids", {30'b0, bus.awvalid, bus.wvalid}, 32'h2);
        wait_drain("drain_write");
        check("wr_dok_after_b", 32'(wr_dok_cyc - b_cyc), 32'd1);

        // Data read behind a write stuck in its response phase.
        b_block = 4;
        data_issue(32'h0000_0008, 2'd2, 1'b1, 4'b0101, 32'h1122_3344, acc_a);
        data_issue(32'h0000_0008, 2'd2, 1'b0, 4'h0, 32'h0, acc_b);
        wait_drain("drain_rd_after_wr");
        check("rd_waits_for_w_idle", 32'(acc_b >= wr_dok_cyc), 32'd1);

        // Reset while AR is pending abandons the read.
        ar_block = 1000;
        data_issue(32'h0000_1008, 2'd2, 1'b0, 4'h0, 32'h0, acc_a);
        check("arvalid_before_reset", {31'b0, bus.arvalid}, 32'd1);
        #2 resetn = 0;
        #1 check("arvalid_async_reset", {30'b0, bus.arvalid, bus.rready}, 32'h0);
        exp_data.delete(); exp_ar.delete();
        ar_block = 0;
        repeat (3) @(negedge clk);
        #2 resetn = 1;
        repeat (10) @(negedge clk);
        data_issue(32'h0000_100C, 2'd2, 1'b0, 4'h0, 32'h0, acc_a);
        wait_drain("drain_after_reset");

        // Randomized traffic on both ports with a stalling slave.
        mode = 1;
        fork
            begin
                int ai;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    inst_issue(32'h1c00_0000 + 32'(4 * $urandom_range(0, 63)), 2'($urandom_range(0, 2)),
                               1'($urandom), ai);
                end
            end
            begin
                int ad;
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    data_issue(32'h0000_1000 + 32'(4 * $urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                               1'($urandom), 4'($urandom), $urandom, ad);
                end
            end
        join
        wait_drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
